// File: rtl/gb_video_pkg.sv
// Shared Game Boy video types and the pixel-to-colour shade map.
// FRAMEBUFFER_SCANOUT_PALETTE_EN selects the DMG green palette instead of grayscale.
package gb_video_pkg;

  localparam int unsigned FB_W      = 160;
  localparam int unsigned FB_H      = 144;
  localparam int unsigned FB_ADDR_W = 16;
  // Raster arithmetic is one bit wider than cx/cy so cx + lead cannot overflow.
  localparam int unsigned POS_W     = 11;

  typedef logic [1:0]  gb_pixel_t;
  typedef logic [23:0] rgb_t;

  function automatic rgb_t shade_to_rgb(input gb_pixel_t px);
    rgb_t c;
`ifdef FRAMEBUFFER_SCANOUT_PALETTE_EN
    unique case (px)
      2'd0: c = 24'h9BBC0F;
      2'd1: c = 24'h8BAC0F;
      2'd2: c = 24'h306230;
      2'd3: c = 24'h0F380F;
    endcase
`else
    unique case (px)
      2'd0: c = 24'hFFFFFF;
      2'd1: c = 24'hAAAAAA;
      2'd2: c = 24'h555555;
      2'd3: c = 24'h000000;
    endcase
`endif
    return c;
  endfunction

endpackage

// File: rtl/scanout_scale_counter.sv
// One axis of the upscaler: maps a raster position to a framebuffer index,
// holding each index for SCALE positions starting at ORIGIN.
module scanout_scale_counter
  import gb_video_pkg::*;
#(
  parameter int unsigned ORIGIN = 80,
  parameter int unsigned SCALE  = 3,
  parameter int unsigned COUNT  = 160
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [POS_W-1:0] position,
  input  logic             advance,
  output logic [7:0]       index,
  output logic             in_range
);

  localparam int unsigned EXTENT = COUNT * SCALE;
  localparam int unsigned SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [7:0]       idx_q, idx_d;

  assign in_range = (position >= POS_W'(ORIGIN)) && (position < POS_W'(ORIGIN + EXTENT));

  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (advance) begin
      if (position == POS_W'(ORIGIN)) begin
        sub_d = '0;
        idx_d = '0;
      end else if (in_range) begin
        if (sub_q == SUB_W'(SCALE - 1)) begin
          sub_d = '0;
          if (idx_q != 8'(COUNT - 1)) idx_d = idx_q + 8'd1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
    end
  end

  // The index reported belongs to the position presented this cycle.
  assign index = idx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer read-side scanout: reads LEAD pixels ahead of (cx, cy) and emits aligned rgb.
// Define FRAMEBUFFER_SCANOUT_PALETTE_EN for the DMG green palette.
module framebuffer_scanout
  import gb_video_pkg::*;
#(
  parameter int unsigned SCALE        = 3,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned READ_LATENCY = 2,
  parameter rgb_t        BORDER_COLOR = 24'h000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [9:0]           cx,
  input  logic [9:0]           cy,
  input  logic [9:0]           frame_width,
  input  logic [9:0]           frame_height,
  output logic [FB_ADDR_W-1:0] fb_read_addr,
  output logic                 fb_read_en,
  input  gb_pixel_t            fb_read_data,
  output rgb_t                 rgb,
  output logic                 in_window
);

  localparam int unsigned X0   = (H_ACTIVE - FB_W * SCALE) / 2;
  localparam int unsigned Y0   = (V_ACTIVE - FB_H * SCALE) / 2;
  localparam int unsigned LEAD = READ_LATENCY + 2;

  if (FB_W * SCALE > H_ACTIVE || FB_H * SCALE > V_ACTIVE) begin : g_bad_fit
    $error("framebuffer_scanout: scaled picture does not fit the active area");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("framebuffer_scanout: READ_LATENCY must be at least 1");
  end

  logic [POS_W-1:0] lx_sum, ly_inc, lx, ly;

  always_comb begin
    lx_sum = {1'b0, cx} + POS_W'(LEAD);
    ly_inc = {1'b0, cy} + POS_W'(1);
    lx     = lx_sum;
    ly     = {1'b0, cy};
    if (lx_sum >= {1'b0, frame_width}) begin
      lx = lx_sum - {1'b0, frame_width};
      ly = (ly_inc >= {1'b0, frame_height}) ? '0 : ly_inc;
    end
  end

  logic [7:0] fb_x, fb_y;
  logic       h_in, v_in, win_la;

  scanout_scale_counter #(
    .ORIGIN (X0),
    .SCALE  (SCALE),
    .COUNT  (FB_W)
  ) u_h_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .position (lx),
    .advance  (1'b1),
    .index    (fb_x),
    .in_range (h_in)
  );

  // Vertical state moves once per lookahead line, at its column 0.
  scanout_scale_counter #(
    .ORIGIN (Y0),
    .SCALE  (SCALE),
    .COUNT  (FB_H)
  ) u_v_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .position (ly),
    .advance  (lx == '0),
    .index    (fb_y),
    .in_range (v_in)
  );

  assign win_la = h_in && v_in;

  // Window flag travels with the read so it lines up with fb_read_data.
  logic [LEAD-2:0] win_pipe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_read_addr <= '0;
      win_pipe_q   <= '0;
      rgb          <= '0;
      in_window    <= 1'b0;
    end else begin
      fb_read_addr <= {fb_y, fb_x};
      win_pipe_q   <= {win_pipe_q[LEAD-3:0], win_la};
      in_window    <= win_pipe_q[LEAD-2];
      rgb          <= win_pipe_q[LEAD-2] ? shade_to_rgb(fb_read_data) : BORDER_COLOR;
    end
  end

  assign fb_read_en = win_pipe_q[0];

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on an 800x525 raster with fb[y][x] = (x+y)%4.
module tb_framebuffer_scanout;

`ifdef FRAMEBUFFER_SCANOUT_PALETTE_EN
  localparam logic [23:0] SH0 = 24'h9BBC0F;
  localparam logic [23:0] SH1 = 24'h8BAC0F;
  localparam logic [23:0] SH2 = 24'h306230;
  localparam logic [23:0] SH3 = 24'h0F380F;
`else
  localparam logic [23:0] SH0 = 24'hFFFFFF;
  localparam logic [23:0] SH1 = 24'hAAAAAA;
  localparam logic [23:0] SH2 = 24'h555555;
  localparam logic [23:0] SH3 = 24'h000000;
`endif
  localparam logic [23:0] BORDER = 24'h000000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  cx, cy, frame_width, frame_height;
  logic [15:0] fb_read_addr;
  logic        fb_read_en;
  logic [1:0]  fb_read_data;
  logic [23:0] rgb;
  logic        in_window;

  int checks = 0;
  int errors = 0;
  int since_jump = 0;

  logic [1:0] mem [65536];
  logic [1:0] rd1 = 2'd0;
  logic [1:0] rd2 = 2'd0;

  always #5 clk = ~clk;

  // RAM with enable plus output register: two cycles of read latency.
  always @(posedge clk) begin
    if (fb_read_en) rd1 <= mem[fb_read_addr];
    rd2 <= rd1;
  end
  assign fb_read_data = rd2;

  framebuffer_scanout dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cx           (cx),
    .cy           (cy),
    .frame_width  (frame_width),
    .frame_height (frame_height),
    .fb_read_addr (fb_read_addr),
    .fb_read_en   (fb_read_en),
    .fb_read_data (fb_read_data),
    .rgb          (rgb),
    .in_window    (in_window)
  );

  function automatic bit pic_win(input int x, input int y);
    return (x >= 80) && (x < 560) && (y >= 24) && (y < 456);
  endfunction

  function automatic logic [23:0] shade(input int v);
    case (v)
      0:       return SH0;
      1:       return SH1;
      2:       return SH2;
      default: return SH3;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb(input int x, input int y);
    if (pic_win(x, y)) return shade(((x - 80) / 3 + (y - 24) / 3) % 4);
    return BORDER;
  endfunction

  // Read enable seen at column x was issued for column x+3.
  function automatic bit exp_en(input int x, input int y);
    int px = x + 3;
    int py = y;
    if (px >= 800) begin
      px -= 800;
      py = (py + 1 >= 525) ? 0 : py + 1;
    end
    return pic_win(px, py);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (cx == 10'd799) begin
      cx = 10'd0;
      cy = (cy == 10'd524) ? 10'd0 : cy + 10'd1;
    end else begin
      cx = cx + 10'd1;
    end
    since_jump++;
  endtask

  task automatic jump(input int x, input int y);
    @(posedge clk);
    #1;
    cx = 10'(x);
    cy = 10'(y);
    since_jump = 0;
  endtask

  task automatic run_to(input int x, input int y, input bit chk);
    int n = 0;
    while (!(int'(cx) == x && int'(cy) == y)) begin
      tick();
      n++;
      if (chk && since_jump >= 4) begin
        checks++;
        if (rgb !== exp_rgb(cx, cy) || in_window !== pic_win(cx, cy)) begin
          errors++;
          $display("FAIL golden_pixel at (%0d,%0d): got rgb=%h win=%b, want rgb=%h win=%b",
                   cx, cy, rgb, in_window, exp_rgb(cx, cy), pic_win(cx, cy));
        end
        checks++;
        if (fb_read_en !== exp_en(cx, cy)) begin
          errors++;
          $display("FAIL golden_read_en at (%0d,%0d): got %b, want %b",
                   cx, cy, fb_read_en, exp_en(cx, cy));
        end
      end
      if (n > 5000) begin
        errors++;
        $display("FAIL run_to_timeout target (%0d,%0d): got (%0d,%0d)", x, y, cx, cy);
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h, want 000000", rgb); end
    checks++;
    if (in_window !== 1'b0) begin errors++; $display("FAIL reset_win: got %b, want 0", in_window); end
    checks++;
    if (fb_read_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b, want 0", fb_read_en); end
    checks++;
    if (fb_read_addr !== 16'h0) begin
      errors++; $display("FAIL reset_addr: got %h, want 0000", fb_read_addr);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_alignment();
    jump(190, 23);
    run_to(200, 23, 1);
    checks++;
    if (rgb !== BORDER || in_window !== 1'b0) begin
      errors++; $display("FAIL border_cy23: got rgb=%h win=%b, want %h 0", rgb, in_window, BORDER);
    end
    run_to(76, 24, 1);
    checks++;
    if (fb_read_en !== 1'b0) begin errors++; $display("FAIL en_cx76: got %b, want 0", fb_read_en); end
    run_to(77, 24, 1);
    checks++;
    if (fb_read_en !== 1'b1 || fb_read_addr !== 16'h0000) begin
      errors++; $display("FAIL read_first: got en=%b addr=%h, want 1 0000", fb_read_en, fb_read_addr);
    end
    run_to(79, 24, 1);
    checks++;
    if (rgb !== BORDER || in_window !== 1'b0) begin
      errors++; $display("FAIL border_cx79: got rgb=%h win=%b, want %h 0", rgb, in_window, BORDER);
    end
    run_to(80, 24, 1);
    checks++;
    if (rgb !== SH0 || in_window !== 1'b1) begin
      errors++; $display("FAIL first_pixel: got rgb=%h win=%b, want %h 1", rgb, in_window, SH0);
    end
    checks++;
    if (fb_read_addr !== 16'h0001) begin
      errors++; $display("FAIL addr_x1: got %h, want 0001", fb_read_addr);
    end
    run_to(82, 24, 1);
    checks++;
    if (rgb !== SH0) begin errors++; $display("FAIL scale_cx82: got %h, want %h", rgb, SH0); end
    run_to(83, 24, 1);
    checks++;
    if (rgb !== SH1) begin errors++; $display("FAIL scale_cx83: got %h, want %h", rgb, SH1); end
  endtask

  task automatic test_scaling();
    run_to(80, 26, 1);
    checks++;
    if (rgb !== SH0) begin errors++; $display("FAIL scale_cy26: got %h, want %h", rgb, SH0); end
    run_to(80, 27, 1);
    checks++;
    if (rgb !== SH1) begin errors++; $display("FAIL scale_cy27: got %h, want %h", rgb, SH1); end
    run_to(84, 27, 1);
    // Visit each line's column-0 lookahead only, keeping the vertical state coherent.
    for (int c = 27; c < 454; c++) begin
      jump(790, c);
      repeat (10) tick();
    end
    jump(790, 454);
    run_to(556, 455, 1);
    checks++;
    if (fb_read_addr !== 16'h8F9F || fb_read_en !== 1'b1) begin
      errors++;
      $display("FAIL last_addr: got en=%b addr=%h, want 1 8F9F", fb_read_en, fb_read_addr);
    end
    run_to(557, 455, 1);
    checks++;
    if (fb_read_en !== 1'b0) begin errors++; $display("FAIL en_cx557: got %b, want 0", fb_read_en); end
    run_to(559, 455, 1);
    checks++;
    if (rgb !== SH2 || in_window !== 1'b1) begin
      errors++; $display("FAIL last_pixel: got rgb=%h win=%b, want %h 1", rgb, in_window, SH2);
    end
    run_to(560, 455, 1);
    checks++;
    if (rgb !== BORDER || in_window !== 1'b0) begin
      errors++; $display("FAIL border_cx560: got rgb=%h win=%b, want %h 0", rgb, in_window, BORDER);
    end
    run_to(200, 456, 1);
    checks++;
    if (rgb !== BORDER || in_window !== 1'b0) begin
      errors++; $display("FAIL border_cy456: got rgb=%h win=%b, want %h 0", rgb, in_window, BORDER);
    end
  endtask

  task automatic test_frame_wrap();
    jump(790, 524);
    run_to(799, 524, 1);
    checks++;
    if (fb_read_en !== 1'b0) begin errors++; $display("FAIL wrap_en: got %b, want 0", fb_read_en); end
    run_to(10, 0, 1);
    jump(790, 23);
    run_to(80, 24, 1);
    checks++;
    if (rgb !== SH0 || in_window !== 1'b1) begin
      errors++; $display("FAIL wrap_realign: got rgb=%h win=%b, want %h 1", rgb, in_window, SH0);
    end
  endtask

  task automatic test_async_reset();
    jump(290, 200);
    run_to(302, 200, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (rgb !== 24'h0 || in_window !== 1'b0) begin
      errors++; $display("FAIL async_rgb: got rgb=%h win=%b, want 000000 0", rgb, in_window);
    end
    checks++;
    if (fb_read_en !== 1'b0 || fb_read_addr !== 16'h0) begin
      errors++; $display("FAIL async_read: got en=%b addr=%h, want 0 0000", fb_read_en, fb_read_addr);
    end
    jump(600, 200);
    tick();
    tick();
    checks++;
    if (rgb !== 24'h0 || fb_read_en !== 1'b0) begin
      errors++; $display("FAIL held_reset: got rgb=%h en=%b, want 000000 0", rgb, fb_read_en);
    end
    #2;
    reset_n = 1'b1;
    run_to(60, 201, 1);
    jump(790, 23);
    run_to(80, 24, 1);
    checks++;
    if (rgb !== SH0 || in_window !== 1'b1) begin
      errors++; $display("FAIL post_reset_first: got rgb=%h win=%b, want %h 1", rgb, in_window, SH0);
    end
    run_to(83, 27, 1);
    checks++;
    if (rgb !== SH2) begin errors++; $display("FAIL post_reset_cy27: got %h, want %h", rgb, SH2); end
  endtask

  initial begin
    reset_n      = 1'b0;
    cx           = 10'd0;
    cy           = 10'd0;
    frame_width  = 10'd800;
    frame_height = 10'd525;
    for (int a = 0; a < 65536; a++) mem[a] = 2'd0;
    for (int y = 0; y < 144; y++) begin
      for (int x = 0; x < 160; x++) mem[y * 256 + x] = 2'((x + y) % 4);
    end
    test_reset();
    test_alignment();
    test_scaling();
    test_frame_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
